// File: rtl/bcd_digit_sequencer_if.sv
// Handshake and digit-stream bundle between a binary-value source, the BCD
// sequencer, and the seven-segment display controller.
interface bcd_digit_sequencer_if #(
   parameter int unsigned WIDTH = 27
);
   logic             start;
   logic [WIDTH-1:0] value;
   logic [3:0]       dig;
   logic [3:0]       pos;
   logic             busy;
   logic             done;
   logic             ovf;

   modport master (
      output start, value,
      input  dig, pos, busy, done, ovf
   );

   modport slave (
      input  start, value,
      output dig, pos, busy, done, ovf
   );
endinterface

// File: rtl/bcd_digit_sequencer.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle) that
// streams one (dig,pos) pair per cycle into the seven-segment display controller.
module bcd_digit_sequencer #(
   parameter int unsigned WIDTH = 27,
   parameter int unsigned NDIG  = 8
) (
   input logic                  clock,
   input logic                  reset,
   bcd_digit_sequencer_if.slave bus
);

   localparam int unsigned BCD_W   = 4 * NDIG;
   localparam int unsigned CNT_W   = $clog2(WIDTH + 1);
   localparam int unsigned IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned MAX_DEC = 10**NDIG - 1;
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_DEC);
   localparam logic [3:0]       POS_NONE = 4'hF;
   localparam logic [3:0]       POS_LAST = 4'(NDIG - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_EMIT    = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_val;
   logic [BCD_W-1:0]   r_bcd;
   logic [CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic [3:0]         r_dig;
   logic [3:0]         r_pos;
   logic               r_busy;
   logic               r_done;
   logic               r_ovf;

   state_t             w_state_nxt;
   logic [WIDTH-1:0]   w_val_nxt;
   logic [BCD_W-1:0]   w_bcd_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic [3:0]         w_dig_nxt;
   logic [3:0]         w_pos_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic               w_ovf_nxt;
   logic [BCD_W-1:0]   w_bcd_adj;
   logic [BCD_W-1:0]   w_bcd_sh;

   // Digit selected for emission: nibble r_idx of the finished BCD word.
   assign w_bcd_sh = r_bcd >> {r_idx, 2'b00};

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_val   <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_dig   <= 4'd0;
         r_pos   <= POS_NONE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_val   <= w_val_nxt;
         r_bcd   <= w_bcd_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_dig   <= w_dig_nxt;
         r_pos   <= w_pos_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_val_nxt   = r_val;
      w_bcd_nxt   = r_bcd;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_dig_nxt   = 4'd0;
      w_pos_nxt   = POS_NONE;
      w_ovf_nxt   = r_ovf;
      // pos only ever holds the last index right after the final emit cycle
      w_done_nxt  = (r_pos == POS_LAST);
      w_bcd_adj   = r_bcd;

      for (int i = 0; i < int'(NDIG); i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_ovf_nxt   = (bus.value > MAX_VAL);
               w_val_nxt   = (bus.value > MAX_VAL) ? MAX_VAL : bus.value;
               w_bcd_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_CONVERT;
            end
         end
         S_CONVERT: begin
            w_bcd_nxt = {w_bcd_adj[BCD_W-2:0], r_val[WIDTH-1]};
            w_val_nxt = {r_val[WIDTH-2:0], 1'b0};
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
               w_idx_nxt   = '0;
               w_state_nxt = S_EMIT;
            end
         end
         S_EMIT: begin
            w_pos_nxt = 4'(r_idx);
            w_dig_nxt = w_bcd_sh[3:0];
            w_idx_nxt = r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(NDIG - 1)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   assign bus.dig  = r_dig;
   assign bus.pos  = r_pos;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Self-checking bench for bcd_digit_sequencer: directed vector table, corner
// sequences, and randomized traffic against a timeline/arithmetic reference model.
module tb_bcd_digit_sequencer;

   localparam int unsigned WIDTH    = 27;
   localparam int unsigned NDIG     = 8;
   localparam longint      MAX_DEC  = 64'd99_999_999;
   localparam longint      LAT_DONE = longint'(WIDTH + NDIG + 1);

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   bit   chk_on = 1'b0;

   bcd_digit_sequencer_if #(.WIDTH(WIDTH)) bus();

   bcd_digit_sequencer #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
      .clock (clock),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic longint pow10(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Inputs as seen by the DUT at the most recent rising edge.
   logic             s_start = 1'b0;
   logic [WIDTH-1:0] s_value = '0;
   logic             s_rst_n = 1'b0;
   always @(posedge clock) begin
      s_start <= bus.start;
      s_value <= bus.value;
      s_rst_n <= rst_n;
   end

   // Reference model: outputs derived from time elapsed since the accepted start.
   longint     cyc = 0, t_acc = 0, m_val = 0;
   bit         active = 1'b0;
   logic [3:0] m_dig = 4'd0, m_pos = 4'hF;
   logic       m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;

   task automatic step_model();
      longint d;
      cyc++;
      if (!s_rst_n) begin
         active = 1'b0;
         m_dig = 4'd0; m_pos = 4'hF; m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
      end else begin
         m_done = active && (cyc - t_acc == LAT_DONE);
         if (s_start && (!active || (cyc - t_acc >= LAT_DONE))) begin
            active = 1'b1;
            t_acc  = cyc;
            m_ovf  = (longint'(s_value) > MAX_DEC);
            m_val  = m_ovf ? MAX_DEC : longint'(s_value);
         end
         d      = cyc - t_acc;
         m_busy = active && (d < longint'(WIDTH + NDIG));
         if (active && d >= longint'(WIDTH + 1) && d <= longint'(WIDTH + NDIG)) begin
            m_pos = 4'(d - longint'(WIDTH) - 1);
            m_dig = 4'((m_val / pow10(int'(m_pos))) % 10);
         end else begin
            m_pos = 4'hF;
            m_dig = 4'd0;
         end
      end
   endtask

   always @(negedge clock) begin
      step_model();
      if (chk_on) begin
         chk($sformatf("cycle %0d {dig,pos,busy,done,ovf}", cyc),
             longint'({bus.dig, bus.pos, bus.busy, bus.done, bus.ovf}),
             longint'({m_dig, m_pos, m_busy, m_done, m_ovf}));
      end
   end

   typedef struct {
      logic [WIDTH-1:0] value;
      logic [31:0]      exp_bcd;
      bit               exp_ovf;
   } vec_t;

   vec_t vecs[8];

   // One conversion observed from the accept edge; optional second start at inj_k.
   task automatic run_conv(input string tag, input logic [WIDTH-1:0] v,
                           input logic [31:0] exp_bcd, input bit exp_ovf,
                           input int inj_k, input logic [WIDTH-1:0] inj_v);
      logic [31:0] got = '0;
      int emits = 0, dones = 0, busy_n = 0, first_k = -1, done_k = -1, p;
      @(negedge clock); bus.start = 1'b1; bus.value = v;
      @(negedge clock); bus.start = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (k == inj_k) begin bus.start = 1'b1; bus.value = inj_v; end
         else bus.start = 1'b0;
         p = int'(bus.pos);
         if (p < int'(NDIG)) begin
            got[p*4 +: 4] = bus.dig;
            emits++;
            if (first_k < 0) first_k = k;
         end
         if (bus.done) begin dones++; done_k = k; end
         if (bus.busy) busy_n++;
         @(negedge clock);
      end
      bus.start = 1'b0;
      chk({tag, " digits"}, longint'(got), longint'(exp_bcd));
      chk({tag, " emit count"}, emits, NDIG);
      chk({tag, " first pos latency"}, first_k, WIDTH + 1);
      chk({tag, " done latency"}, done_k, WIDTH + NDIG + 1);
      chk({tag, " done pulses"}, dones, 1);
      chk({tag, " busy cycles"}, busy_n, WIDTH + NDIG);
      chk({tag, " ovf held"}, longint'(bus.ovf), longint'(exp_ovf));
   endtask

   task automatic abort_at(input string tag, input int k_abort);
      int stray = 0;
      @(negedge clock); bus.start = 1'b1; bus.value = 27'd100_000_000;
      @(negedge clock); bus.start = 1'b0;
      repeat (k_abort) @(negedge clock);
      chk({tag, " ovf before reset"}, longint'(bus.ovf), 1);
      rst_n = 1'b0;
      @(negedge clock); rst_n = 1'b1;
      chk({tag, " pos after reset"}, longint'(bus.pos), 15);
      chk({tag, " busy after reset"}, longint'(bus.busy), 0);
      chk({tag, " done after reset"}, longint'(bus.done), 0);
      chk({tag, " ovf after reset"}, longint'(bus.ovf), 0);
      chk({tag, " dig after reset"}, longint'(bus.dig), 0);
      repeat (45) begin
         @(negedge clock);
         if (bus.pos != 4'hF || bus.done || bus.busy) stray++;
      end
      chk({tag, " quiet after abort"}, stray, 0);
      run_conv({tag, " fresh start"}, 27'd12_345_678, 32'h1234_5678, 1'b0, -1, '0);
   endtask

   initial begin
      int dones, emits, dsum, first_done_busy;
      bus.start = 1'b0;
      bus.value = '0;

      vecs[0] = '{27'd12_345_678,  32'h1234_5678, 1'b0};
      vecs[1] = '{27'd0,           32'h0000_0000, 1'b0};
      vecs[2] = '{27'd100_000_000, 32'h9999_9999, 1'b1};
      vecs[3] = '{27'd99_999_999,  32'h9999_9999, 1'b0};
      vecs[4] = '{27'd42,          32'h0000_0042, 1'b0};
      vecs[5] = '{27'd134_217_727, 32'h9999_9999, 1'b1};
      vecs[6] = '{27'd10_000_000,  32'h1000_0000, 1'b0};
      vecs[7] = '{27'd90_817_263,  32'h9081_7263, 1'b0};

      repeat (2) @(negedge clock);
      chk("reset dig",  longint'(bus.dig), 0);
      chk("reset pos",  longint'(bus.pos), 15);
      chk("reset busy", longint'(bus.busy), 0);
      chk("reset done", longint'(bus.done), 0);
      chk("reset ovf",  longint'(bus.ovf), 0);
      chk_on = 1'b1;
      rst_n  = 1'b1;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 8; i++) begin
         run_conv($sformatf("vec%0d", i), vecs[i].value, vecs[i].exp_bcd, vecs[i].exp_ovf, -1, '0);
      end

      run_conv("start while busy", 27'd12_345_678, 32'h1234_5678, 1'b0, 5, 27'd1);
      run_conv("start while busy ovf", 27'd100_000_000, 32'h9999_9999, 1'b1, 5, 27'd1);

      abort_at("abort convert", 10);
      abort_at("abort emit", 30);

      // Start held high: back-to-back conversions, restart coincides with done.
      dones = 0; emits = 0; dsum = 0; first_done_busy = -1;
      @(negedge clock); bus.start = 1'b1; bus.value = 27'd42;
      for (int k = 0; k < 140; k++) begin
         @(negedge clock);
         if (k == 99) bus.start = 1'b0;
         if (bus.pos < 4'(NDIG)) begin emits++; dsum += int'(bus.dig); end
         if (bus.done) begin
            dones++;
            if (first_done_busy < 0) first_done_busy = int'(bus.busy);
         end
      end
      chk("held start done pulses", dones, 3);
      chk("held start emits", emits, 3 * NDIG);
      chk("held start digit sum", dsum, 18);
      chk("held start restart on done", first_done_busy, 1);

      // Randomized traffic, checked cycle by cycle against the model.
      for (int n = 0; n < 1500; n++) begin
         @(negedge clock);
         rst_n     = ($urandom_range(0, 299) != 0);
         bus.start = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 3))
            0:       bus.value = WIDTH'($urandom_range(0, 999));
            1:       bus.value = WIDTH'($urandom);
            2:       bus.value = WIDTH'($urandom_range(99_999_990, 100_000_010));
            default: bus.value = WIDTH'($urandom_range(0, 99_999_999));
         endcase
      end
      @(negedge clock);
      rst_n = 1'b1; bus.start = 1'b0;
      repeat (40) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
